if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Input-feature (ifmap) fetch engine directly downstream of the ifmap controller.
- While the controller holds if_read, the block walks a 2-D ifmap tile in the on-chip ifmap buffer and streams one ROWS-lane vector per cycle to the systolic array feeder.
- Returns a one-cycle if_done pulse after the last vector has been accepted.
- clr_if from the controller restarts the walk.

Parameters:
- ADDR_W, 16, ifmap buffer word-address width.
- DATA_W, 8, bits per lane element.
- ROWS, 8, lanes per buffer word and per output vector.
- DIM_W, 10, width of the tile dimension and pitch config fields.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- if_read  in  1  run enable from the controller.
- clr_if  in  1  restart walk; valid only while if_read=1, X otherwise.
- cfg_base  in  ADDR_W  word address of tile element (0,0).
- cfg_width  in  DIM_W  columns per tile row.
- cfg_height  in  DIM_W  tile rows.
- cfg_pitch  in  DIM_W  words between starts of consecutive rows.
- mem_rd_en  out  1  buffer read strobe.
- mem_addr  out  ADDR_W  buffer read address.
- mem_rdata  in  ROWS*DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- if_data  out  ROWS*DATA_W  output vector.
- if_valid  out  1  if_data valid.
- if_stall  in  1  downstream backpressure; a vector transfers when if_valid=1 and if_stall=0.
- if_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE; mem_rd_en, if_valid and if_done are 0; mem_addr and if_data are 0; all counters are 0; skid buffer is empty.
- States:
  - IDLE: waits for if_read=1 with clr_if=1. Latches cfg_* into shadow registers, sets row=0, col=0, row_base=cfg_base, then goes to FETCH. Config is ignored at all other times.
  - FETCH:
    - mem_rd_en = !if_stall && !skid_full.
    - mem_addr = row_base + col, modulo 2^ADDR_W.
    - Each issued read advances col. On col=width-1, col returns to 0, row_base += pitch and row advances.
    - When the read for (height-1, width-1) is issued, the state goes to DRAIN.
  - DRAIN: no reads issued. Remains until every in-flight read and the skid entry have transferred.
    - if_done=1 for exactly the cycle after the final transfer, then state goes to DONE.
  - DONE: waits until if_read=0, then goes to IDLE. The controller drops if_read one cycle after sampling if_done, so the block must not restart on that stale high.
- Output path:
  - Read data registers into if_data with if_valid set.
  - If the output register is held by a stall, the arriving word goes to a one-entry skid buffer.
  - Zero loss, zero duplication, strict raster order.
  - A stall never drops if_valid, and if_data stays stable while stalled.
- Throughput: one vector per cycle with no stall. First if_valid appears 2 cycles after the IDLE→FETCH edge.
- Zero dimension (width=0 or height=0): no reads. if_done is pulsed 1 cycle after the start edge.
- clr_if=1 with if_read=1 in FETCH or DRAIN (restart mid-operation):
  - In-flight data is discarded, if_valid is cleared and the skid buffer is flushed.
  - Config is re-latched and the state goes to FETCH the next cycle.
  - No if_done is generated for the aborted walk.
- if_read=0 in FETCH or DRAIN (abort): state goes to IDLE, outputs are cleared, no if_done.
- rst at any time forces the reset values immediately.

Optional Feature:
- Macro: IF_ZERO_PAD_EN.
- When defined:
  - Extra input cfg_pad [1:0] is latched at start.
  - Each tile dimension grows by 2*pad.
  - Positions inside the pad border issue no memory read and emit an all-zero vector. Pad vectors obey the same stall and ordering rules.
  - Addresses of interior elements are unchanged.
- When undefined: no cfg_pad port, and behaviour is exactly as above.

Test Plan:
- Nominal walk: base=0x100, width=4, height=3, pitch=8, no stall → addresses 0x100-0x103, 0x108-0x10B, 0x110-0x113. 12 consecutive if_valid cycles; if_done pulses once, the cycle after the 12th transfer.
- Backpressure: same tile with if_stall high on cycles 3-5 and 9 → still exactly 12 transfers in raster order; if_data stable while stalled; no duplicates.
- Zero dimension: width=0, height=5 → mem_rd_en never asserts; if_done=1 one cycle after start; DONE holds until if_read falls.
- Restart: clr_if pulsed with if_read=1 after the 5th transfer, new base=0x200 → old data flushed, next address 0x200, no if_done for the aborted walk.
- Async reset mid-FETCH → all outputs 0 within the reset cycle without waiting for a clock edge; a subsequent start proceeds normally.
- IF_ZERO_PAD_EN, pad=1, 2x2 tile at base 0 → 16 vectors: the 12 border vectors are zero, and the interior 4 read addresses 0, 1, pitch, pitch+1.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
//   Bundle of every non-clock signal of the ifmap fetch unit: the controller
//   handshake and tile configuration, the ifmap buffer read port, and the
//   vector stream towards the systolic array feeder.
//
//   modport master : environment side (controller, buffer, feeder).
//   modport slave  : the fetch unit itself.
//
//   Signals
//     if_read, clr_if                    controller run enable / restart
//     cfg_base, cfg_width, cfg_height,
//     cfg_pitch                          tile geometry, latched at start
//     cfg_pad                            pad border width (IF_ZERO_PAD_EN only)
//     mem_rd_en, mem_addr, mem_rdata     buffer read port, 1-cycle latency
//     if_data, if_valid, if_stall        output vector stream
//     if_done                            one-cycle completion pulse
//
//   Build option: IF_ZERO_PAD_EN adds the cfg_pad field.
// -----------------------------------------------------------------------------
interface if_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int ROWS   = 8,
  parameter int DIM_W  = 10
) ();
  logic                     if_read;
  logic                     clr_if;
  logic [ADDR_W-1:0]        cfg_base;
  logic [DIM_W-1:0]         cfg_width;
  logic [DIM_W-1:0]         cfg_height;
  logic [DIM_W-1:0]         cfg_pitch;
`ifdef IF_ZERO_PAD_EN
  logic [1:0]               cfg_pad;
`endif
  logic                     mem_rd_en;
  logic [ADDR_W-1:0]        mem_addr;
  logic [ROWS*DATA_W-1:0]   mem_rdata;
  logic [ROWS*DATA_W-1:0]   if_data;
  logic                     if_valid;
  logic                     if_stall;
  logic                     if_done;

  modport master (
    output if_read, clr_if, cfg_base, cfg_width, cfg_height, cfg_pitch,
`ifdef IF_ZERO_PAD_EN
    output cfg_pad,
`endif
    output mem_rdata, if_stall,
    input  mem_rd_en, mem_addr, if_data, if_valid, if_done
  );

  modport slave (
    input  if_read, clr_if, cfg_base, cfg_width, cfg_height, cfg_pitch,
`ifdef IF_ZERO_PAD_EN
    input  cfg_pad,
`endif
    input  mem_rdata, if_stall,
    output mem_rd_en, mem_addr, if_data, if_valid, if_done
  );
endinterface

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//   Walks a 2-D ifmap tile in raster order out of the ifmap buffer and streams
//   one ROWS-lane vector per cycle to the systolic array feeder. A one-entry
//   skid buffer absorbs the read that is already in flight when the feeder
//   stalls, so nothing is lost or duplicated. if_done pulses for one cycle
//   after the last vector has transferred.
//
//   Ports
//     clk  : clock
//     rst  : asynchronous, active-high reset
//     bus  : if_fetch_unit_if.slave (controller, buffer port, output stream)
//
//   Build option: IF_ZERO_PAD_EN surrounds the tile with a cfg_pad-wide border
//   of all-zero vectors that issue no buffer reads.
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int ROWS   = 8,
  parameter int DIM_W  = 10
) (
  input  logic           clk,
  input  logic           rst,
  if_fetch_unit_if.slave bus
);

  localparam int VEC_W = ROWS * DATA_W;
  // Walk counters cover the padded dimensions (up to 2^DIM_W-1 + 6).
  localparam int CNT_W = DIM_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   width_q, width_d;      // padded columns
  logic [CNT_W-1:0]   height_q, height_d;    // padded rows
  logic [DIM_W-1:0]   pitch_q, pitch_d;
  logic [1:0]         pad_q, pad_d;
  logic [CNT_W-1:0]   row_q, row_d;
  logic [CNT_W-1:0]   col_q, col_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;
  logic               rd_pend_q, rd_pend_d;  // a slot issued last cycle
  logic               rd_pad_q, rd_pad_d;    // that slot is a pad vector
  logic               skid_full_q, skid_full_d;
  logic [VEC_W-1:0]   skid_data_q, skid_data_d;
  logic [VEC_W-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  logic [1:0]         cfg_pad_in;
  logic [CNT_W-1:0]   pad_ext;
  logic               is_pad;
  logic               interior_row;
  logic               issue;
  logic               last_col;
  logic               last_row;
  logic               out_free;
  logic [VEC_W-1:0]   arr_data;
  logic               zero_dim;
  logic               start;
  logic               abort;

`ifdef IF_ZERO_PAD_EN
  assign cfg_pad_in = bus.cfg_pad;
`else
  assign cfg_pad_in = 2'd0;
`endif

  assign pad_ext      = CNT_W'(pad_q);
  assign interior_row = (row_q >= pad_ext) && (row_q < height_q - pad_ext);
  assign is_pad       = !interior_row || (col_q < pad_ext) ||
                        (col_q >= width_q - pad_ext);

  // A slot (read or pad vector) is issued only when the pipeline can take it:
  // with the feeder not stalling and the skid empty, the word arriving next
  // cycle always has either the output register or the skid to land in.
  // Read enable/address stay combinational so they react to if_stall at once.
  assign issue         = (state_q == S_FETCH) && !bus.if_stall && !skid_full_q;
  assign bus.mem_rd_en = issue && !is_pad;
  assign bus.mem_addr  = (state_q == S_FETCH) ?
                         row_base_q + ADDR_W'(col_q - pad_ext) : '0;

  assign last_col = (col_q == width_q - CNT_W'(1));
  assign last_row = (row_q == height_q - CNT_W'(1));
  assign out_free = !valid_q || !bus.if_stall;
  assign arr_data = rd_pad_q ? '0 : bus.mem_rdata;

  assign zero_dim = (bus.cfg_width == '0) || (bus.cfg_height == '0);
  // clr_if is only meaningful under if_read; DONE ignores a stale request.
  assign start    = bus.if_read && bus.clr_if && (state_q != S_DONE);
  assign abort    = !bus.if_read && ((state_q == S_FETCH) || (state_q == S_DRAIN));

  always_comb begin
    // NOTE: every _d starts from its _q value (or a fixed default) before any
    // branch, so no path through this block can infer a latch.
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    pitch_d     = pitch_q;
    pad_d       = pad_q;
    row_d       = row_q;
    col_d       = col_q;
    row_base_d  = row_base_q;
    rd_pend_d   = issue;
    rd_pad_d    = issue && is_pad;
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    data_d      = data_q;
    valid_d     = valid_q;
    done_d      = 1'b0;

    // Output path: the skid always holds an older word than the one arriving,
    // so it drains first to keep raster order.
    if (out_free) begin
      if (skid_full_q) begin
        data_d      = skid_data_q;
        valid_d     = 1'b1;
        skid_full_d = rd_pend_q;
        skid_data_d = arr_data;
      end else begin
        valid_d = rd_pend_q;
        if (rd_pend_q) data_d = arr_data;
      end
    end else if (rd_pend_q) begin
      skid_full_d = 1'b1;
      skid_data_d = arr_data;
    end

    case (state_q)
      S_IDLE: ;
      S_FETCH: begin
        if (issue) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + CNT_W'(1);
            // Pad rows have no buffer words, so only real rows move the base.
            if (interior_row) row_base_d = row_base_q + ADDR_W'(pitch_q);
            if (last_row) state_d = S_DRAIN;
          end else begin
            col_d = col_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // Final transfer happens on this edge when nothing else is queued.
        if (!rd_pend_q && !skid_full_q && out_free) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!bus.if_read) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d     = S_IDLE;
      rd_pend_d   = 1'b0;
      rd_pad_d    = 1'b0;
      skid_full_d = 1'b0;
      valid_d     = 1'b0;
      data_d      = '0;
      done_d      = 1'b0;
    end else if (start) begin
      width_d     = CNT_W'(bus.cfg_width) + CNT_W'({cfg_pad_in, 1'b0});
      height_d    = CNT_W'(bus.cfg_height) + CNT_W'({cfg_pad_in, 1'b0});
      pitch_d     = bus.cfg_pitch;
      pad_d       = cfg_pad_in;
      row_d       = '0;
      col_d       = '0;
      row_base_d  = bus.cfg_base;
      // An empty tile skips straight to DRAIN, which completes next edge.
      state_d     = zero_dim ? S_DRAIN : S_FETCH;
      rd_pend_d   = 1'b0;
      rd_pad_d    = 1'b0;
      skid_full_d = 1'b0;
      valid_d     = 1'b0;
      data_d      = '0;
      done_d      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset as well because if_data must read
      // zero out of reset; the skid payload follows for uniformity.
      state_q     <= S_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      pitch_q     <= '0;
      pad_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      row_base_q  <= '0;
      rd_pend_q   <= 1'b0;
      rd_pad_q    <= 1'b0;
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      pitch_q     <= pitch_d;
      pad_q       <= pad_d;
      row_q       <= row_d;
      col_q       <= col_d;
      row_base_q  <= row_base_d;
      rd_pend_q   <= rd_pend_d;
      rd_pad_q    <= rd_pad_d;
      skid_full_q <= skid_full_d;
      skid_data_q <= skid_data_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.if_data  = data_q;
  assign bus.if_valid = valid_q;
  assign bus.if_done  = done_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
//   Self-checking bench for if_fetch_unit. A reference model expands each tile
//   into the expected raster list of read addresses and output vectors; a
//   negedge monitor matches reads and transfers against those lists and checks
//   stall stability and if_done timing. Stimulus: directed walks plus random
//   geometry and random backpressure. IF_ZERO_PAD_EN enables the pad walks.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int ROWS   = 8;
  localparam int DIM_W  = 10;
  localparam int VEC_W  = ROWS * DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROWS(ROWS), .DIM_W(DIM_W)) bus ();

  if_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROWS(ROWS), .DIM_W(DIM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [VEC_W-1:0] got,
                       input logic [VEC_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Buffer contents: a distinct word per address.
  function automatic logic [VEC_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
    return {a, ~a, a ^ 16'hA5C3, a + 16'h1357};
  endfunction

  // Buffer read port with one cycle of latency; garbage otherwise.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem_fn(bus.mem_addr);
    else               bus.mem_rdata <= {$urandom, $urandom};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference expectations and monitor bookkeeping.
  logic [ADDR_W-1:0] exp_addr[$];
  logic [VEC_W-1:0]  exp_data[$];
  int                n_vec_exp;
  int                start_cyc;
  int                xfer_cnt;
  int                last_xfer_cyc;
  int                first_valid_cyc;
  int                done_cnt;
  int                done_cyc;
  bit                hold_pend = 0;
  logic [VEC_W-1:0]  hold_data;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 0;
    end else begin
      if (bus.mem_rd_en) begin
        if (exp_addr.size() == 0) check("rd_extra", {63'd0, bus.mem_rd_en}, '0);
        else                      check("rd_addr", bus.mem_addr, exp_addr.pop_front());
      end
      if (bus.if_valid && !bus.if_stall) begin
        if (exp_data.size() == 0) check("xfer_extra", {63'd0, bus.if_valid}, '0);
        else                      check("xfer_data", bus.if_data, exp_data.pop_front());
        xfer_cnt++;
        last_xfer_cyc = cyc;
      end
      if (hold_pend) begin
        check("hold_valid", {63'd0, bus.if_valid}, 64'd1);
        check("hold_data", bus.if_data, hold_data);
      end
      hold_pend = bus.if_valid && bus.if_stall;
      hold_data = bus.if_data;
      if (bus.if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.if_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Raster expansion of the (optionally padded) tile.
  task automatic build_model(input int base, input int w, input int h,
                             input int pitch, input int pad);
    logic [ADDR_W-1:0] a;
    exp_addr.delete();
    exp_data.delete();
    if (w == 0 || h == 0) return;
    for (int r = 0; r < h + 2 * pad; r++) begin
      for (int c = 0; c < w + 2 * pad; c++) begin
        if (r < pad || r >= h + pad || c < pad || c >= w + pad) begin
          exp_data.push_back('0);
        end else begin
          a = ADDR_W'(base + (r - pad) * pitch + (c - pad));
          exp_addr.push_back(a);
          exp_data.push_back(mem_fn(a));
        end
      end
    end
  endtask

  // Called at posedge+1; drives the start request through one clock edge.
  task automatic start_walk(input int base, input int w, input int h,
                            input int pitch, input int pad);
    bus.cfg_base   = ADDR_W'(base);
    bus.cfg_width  = DIM_W'(w);
    bus.cfg_height = DIM_W'(h);
    bus.cfg_pitch  = DIM_W'(pitch);
`ifdef IF_ZERO_PAD_EN
    bus.cfg_pad    = 2'(pad);
`endif
    bus.if_read = 1'b1;
    bus.clr_if  = 1'b1;
    @(posedge clk); #1;
    bus.clr_if = 1'b0;
    // Config must be latched: scramble it after the start edge.
    bus.cfg_base   = ADDR_W'($urandom);
    bus.cfg_width  = DIM_W'($urandom);
    bus.cfg_height = DIM_W'($urandom);
    bus.cfg_pitch  = DIM_W'($urandom);
    build_model(base, w, h, pitch, pad);
    n_vec_exp       = exp_data.size();
    start_cyc       = cyc;
    xfer_cnt        = 0;
    last_xfer_cyc   = -1;
    first_valid_cyc = -1;
    done_cnt        = 0;
    done_cyc        = -1;
    hold_pend       = 0;
  endtask

  // mode 0: no stall, 1: stall on cycles 3-5 and 9, 2: random stall.
  // stop_xfers = 0 runs until if_done, otherwise until that many transfers.
  task automatic run(input int mode, input int stop_xfers);
    bit reached = 0;
    for (int k = 0; k < 600 && !reached; k++) begin
      case (mode)
        1:       bus.if_stall = (cyc - start_cyc) inside {3, 4, 5, 9};
        2:       bus.if_stall = ($urandom_range(0, 2) == 0);
        default: bus.if_stall = 1'b0;
      endcase
      @(posedge clk); #1;
      reached = (stop_xfers == 0) ? (done_cnt != 0) : (xfer_cnt >= stop_xfers);
    end
    bus.if_stall = 1'b0;
    check("timeout", {63'd0, reached}, 64'd1);
  endtask

  // In DONE: a held start request must be ignored, then if_read drops.
  task automatic finish_walk();
    bus.clr_if = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    bus.clr_if  = 1'b0;
    bus.if_read = 1'b0;
    @(posedge clk); #1;
    check("done_count", done_cnt, 64'd1);
    check("vec_left", exp_data.size(), 64'd0);
    check("addr_left", exp_addr.size(), 64'd0);
    check("xfer_count", xfer_cnt, n_vec_exp);
    if (n_vec_exp == 0) check("done_cyc", done_cyc, start_cyc + 1);
    else                check("done_cyc", done_cyc, last_xfer_cyc + 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"}, {63'd0, bus.mem_rd_en}, '0);
    check({tag, "_addr"},  bus.mem_addr, '0);
    check({tag, "_valid"}, {63'd0, bus.if_valid}, '0);
    check({tag, "_done"},  {63'd0, bus.if_done}, '0);
    check({tag, "_data"},  bus.if_data, '0);
  endtask

  initial begin
    bus.if_read    = 1'b0;
    bus.clr_if     = 1'b0;
    bus.if_stall   = 1'b0;
    bus.cfg_base   = '0;
    bus.cfg_width  = '0;
    bus.cfg_height = '0;
    bus.cfg_pitch  = '0;
`ifdef IF_ZERO_PAD_EN
    bus.cfg_pad    = '0;
`endif
    #12;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal walk, no stall: 12 back-to-back vectors.
    start_walk(16'h100, 4, 3, 8, 0);
    run(0, 0);
    check("first_valid_lat", first_valid_cyc, start_cyc + 2);
    check("last_xfer_cyc", last_xfer_cyc, start_cyc + 13);
    finish_walk();

    // Scripted backpressure.
    start_walk(16'h100, 4, 3, 8, 0);
    run(1, 0);
    finish_walk();

    // Zero dimension.
    start_walk(16'h040, 0, 5, 8, 0);
    run(0, 0);
    finish_walk();

    // Restart after the 5th transfer.
    start_walk(16'h100, 4, 3, 8, 0);
    run(0, 5);
    start_walk(16'h200, 3, 2, 4, 0);
    run(0, 0);
    finish_walk();

    // Asynchronous reset mid-FETCH, then a normal walk.
    start_walk(16'h300, 6, 4, 10, 0);
    run(0, 3);
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_rst");
    bus.if_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_walk(16'h100, 4, 3, 8, 0);
    run(0, 0);
    finish_walk();

    // Address wrap modulo 2^ADDR_W.
    start_walk(16'hFFFE, 4, 2, 3, 0);
    run(2, 0);
    finish_walk();

    // Random geometry with random backpressure.
    for (int i = 0; i < 10; i++) begin
      start_walk(int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(1, 6)),
                 int'($urandom_range(1, 4)), int'($urandom_range(0, 15)), 0);
      run(2, 0);
      finish_walk();
    end

`ifdef IF_ZERO_PAD_EN
    start_walk(0, 2, 2, 8, 1);
    run(0, 0);
    finish_walk();
    for (int i = 0; i < 4; i++) begin
      start_walk(int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(1, 3)),
                 int'($urandom_range(1, 3)), int'($urandom_range(3, 12)),
                 int'($urandom_range(0, 3)));
      run(2, 0);
      finish_walk();
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
